secded_scrubber: RTL and testbench
==================================

# secded_scrubber

Memory scrubber controller for the 13-bit SECDED datapath. On a start pulse it walks every word of a single-port codeword memory and passes each word through the external `SECDEDdecoder`. Single-bit errors are corrected by writing the decoder's `outCode` back; double-bit errors are counted and the first failing address is latched. The block sits between the codeword RAM and the decoder and owns both for the duration of a scan.

## Interface
- `DEPTH`, 16: number of codewords scanned (addresses 0..DEPTH-1), ≥2
- `AW`, 4: address width, ≥ clog2(DEPTH)
- `clock` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `start` input 1: scan request, sampled only in IDLE
- `abort` input 1: cancel scan in progress
- `mem_addr` output AW: RAM address
- `mem_re` output 1: RAM read enable; data valid on `mem_rdata` the following cycle
- `mem_rdata` input 13: RAM read data
- `mem_we` output 1: RAM write enable
- `mem_wdata` output 13: RAM write data
- `dec_inCode` output 13: to decoder `inCode`
- `dec_outCode` input 13: decoder corrected codeword
- `dec_is1BitErr` input 1: decoder single-bit flag
- `dec_is2BitErr` input 1: decoder double-bit flag
- `busy` output 1: high in any state other than IDLE
- `done` output 1: one-cycle pulse at normal scan completion
- `corr_count` output 8: corrected words in the last or current scan, saturating
- `uncorr_count` output 8: uncorrectable words, saturating
- `bad_valid` output 1: at least one uncorrectable word seen in this scan
- `first_bad_addr` output AW: address of the first uncorrectable word

## Operation
- FSM states: IDLE, READ, CHECK, WRITE, DONE.
- IDLE:
  - When `start`=1, clear `corr_count`, `uncorr_count`, `bad_valid`, `first_bad_addr`.
  - Set `addr`=0 and go to READ.
- READ: drive `mem_re`=1 with `mem_addr`=`addr`, then go to CHECK.
- CHECK:
  - Drive `dec_inCode`=`mem_rdata` combinationally; sample the decoder flags at the end of the cycle.
  - `is1BitErr`:
    - register `dec_outCode` into the write-data register;
    - increment `corr_count`;
    - go to WRITE.
  - `is2BitErr` (takes priority if both flags are high):
    - increment `uncorr_count`, no write;
    - if `bad_valid`=0, latch `first_bad_addr`=`addr` and set `bad_valid`=1.
  - Clean word, or after a double-bit error: advance (see below).
- WRITE: drive `mem_we`=1, `mem_addr`=`addr`, `mem_wdata`=registered correction, then advance.
- Advance rule: if `addr`==DEPTH-1 go to DONE, else `addr`+1 and go to READ.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Counters saturate at 255 and never wrap.
- `abort`:
  - Any non-IDLE state goes to IDLE at the next edge.
  - Counters and `bad_valid` are retained; no `done` pulse.
  - A WRITE cycle already being presented completes, because `mem_we` is decoded from the current state.
  - `abort` has priority over the advance rule and the DONE transition.
- `start` is ignored outside IDLE. `start` and `abort` high together in IDLE: the scan starts and `abort` is ignored.
- Mutual exclusion: `mem_re` and `mem_we` are never high in the same cycle; `mem_we` is high only in WRITE.
- Idle outputs: `dec_inCode`=0 outside CHECK; `mem_addr` holds `addr`; `mem_wdata` holds its register.

## Timing
- Reset values (asynchronous):
  - state=IDLE, `addr`=0;
  - `mem_re`=`mem_we`=0, `mem_wdata`=0, `dec_inCode`=0;
  - `busy`=`done`=0, counters=0, `bad_valid`=0, `first_bad_addr`=0.
- Reset mid-scan: same values; any write in progress is dropped.
- Cycle 0 is the edge that samples `start`.
  - Cycles 1, 2 are READ and CHECK for word 0.
  - A clean word costs 2 cycles; a corrected word costs 3.
- Scan length with C corrected words: `done` is high in cycle 2·DEPTH+C+1, and `busy` falls in the following cycle.
- Count and `first_bad_addr` updates are visible in the cycle after CHECK.
- RAM contract: synchronous read with 1-cycle latency; synchronous write.
- Decoder contract: purely combinational within CHECK.

## Test plan
- Clean scan: all 16 words valid codewords, `start` pulse → `done` in cycle 33; `corr_count`=0, `uncorr_count`=0, `bad_valid`=0, no `mem_we`.
- Single-bit correction: word 5 has bit 6 flipped → one WRITE at address 5 with the corrected word; RAM re-read shows no error; `corr_count`=1; `done` in cycle 34.
- Double-bit errors: words 3 and 9 each have 2 bits flipped → `uncorr_count`=2, `first_bad_addr`=3, `bad_valid`=1; no writes; `done` in cycle 33.
- Abort: `abort` pulsed during word 7 CHECK after 1 correction → IDLE next edge, `busy`=0, no `done`, `corr_count`=1 retained.
- Reset during WRITE: assert `reset` mid-cycle → all outputs go to reset values immediately; a new `start` rescans from address 0 with cleared counters.
- `start` while busy: pulses during a scan are ignored, so only one `done` appears; a 300-word stress case with all single-bit errors (DEPTH=300, AW=9) → `corr_count` saturates at 255.

Source files
------------

// File: rtl/secded_scrubber_if.sv
// Bus between the scrubber, the codeword RAM and the external SECDED decoder.
// The scrubber drives the master side; the RAM/decoder pair sits on the slave side.
interface secded_scrubber_if #(
  parameter int AW = 4
);
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [12:0]   mem_rdata;
  logic          mem_we;
  logic [12:0]   mem_wdata;
  logic [12:0]   dec_inCode;
  logic [12:0]   dec_outCode;
  logic          dec_is1BitErr;
  logic          dec_is2BitErr;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata, dec_inCode,
    input  mem_rdata, dec_outCode, dec_is1BitErr, dec_is2BitErr
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata, dec_inCode,
    output mem_rdata, dec_outCode, dec_is1BitErr, dec_is2BitErr
  );
endinterface

// File: rtl/secded_scrubber.sv
// Walks every codeword of the RAM through the SECDED decoder, writes back single-bit
// corrections and records double-bit errors (saturating counts, first failing address).
module secded_scrubber #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  secded_scrubber_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [7:0]          corr_count,
  output logic [7:0]          uncorr_count,
  output logic                bad_valid,
  output logic [AW-1:0]       first_bad_addr
);
  localparam int DATA_W = 13;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        corr_q, corr_d;
  logic [7:0]        uncorr_q, uncorr_d;
  logic              bad_valid_q, bad_valid_d;
  logic [AW-1:0]     first_bad_q, first_bad_d;
  logic              advance;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    bad_valid_d = bad_valid_q;
    first_bad_d = first_bad_q;
    advance     = 1'b0;

    // abort wins over everything except the IDLE start decision
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            corr_d      = '0;
            uncorr_d    = '0;
            bad_valid_d = 1'b0;
            first_bad_d = '0;
            addr_d      = '0;
            state_d     = S_READ;
          end
        end
        S_READ:  state_d = S_CHECK;
        S_CHECK: begin
          if (bus.dec_is2BitErr) begin
            uncorr_d = sat_inc(uncorr_q);
            if (!bad_valid_q) begin
              bad_valid_d = 1'b1;
              first_bad_d = addr_q;
            end
            advance = 1'b1;
          end else if (bus.dec_is1BitErr) begin
            wdata_d = bus.dec_outCode;
            corr_d  = sat_inc(corr_q);
            state_d = S_WRITE;
          end else begin
            advance = 1'b1;
          end
        end
        S_WRITE: advance = 1'b1;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (advance) begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_READ;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      corr_q      <= '0;
      uncorr_q    <= '0;
      bad_valid_q <= 1'b0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      bad_valid_q <= bad_valid_d;
      first_bad_q <= first_bad_d;
    end
  end

  // RAM strobes are decoded from the current state, so re/we can never overlap
  assign bus.mem_addr   = addr_q;
  assign bus.mem_re     = (state_q == S_READ);
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_wdata  = wdata_q;
  assign bus.dec_inCode = (state_q == S_CHECK) ? bus.mem_rdata : '0;

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign corr_count     = corr_q;
  assign uncorr_count   = uncorr_q;
  assign bad_valid      = bad_valid_q;
  assign first_bad_addr = first_bad_q;
endmodule

// File: tb/tb_secded_scrubber.sv
// Directed bench for secded_scrubber: behavioural RAM + Hamming(12,8)+parity decoder,
// one 16-word instance for the functional cases and a 300-word instance for saturation.
module tb_secded_scrubber;
  logic clock = 1'b0;
  logic reset;
  logic start_s, abort_s, start_b;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] c;
    logic [3:0]  s;
    int pos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    c = '0;
    s = '0;
    for (int k = 0; k < 8; k++) c[pos[k]] = d[k];
    for (int i = 1; i < 13; i++) if (c[i]) s ^= 4'(i);
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[0] = ^c[12:1];
    return c;
  endfunction

  // {is2, is1, corrected}
  function automatic logic [14:0] dec(input logic [12:0] c);
    logic [3:0]  s;
    logic [12:0] o;
    s = '0;
    for (int i = 1; i < 13; i++) if (c[i]) s ^= 4'(i);
    o = c;
    if (^c) return {1'b0, 1'b1, c ^ (13'd1 << s)};
    if (s != 4'd0) return {1'b1, 1'b0, o};
    return {2'b00, o};
  endfunction

  // ---------------- 16-word instance ----------------
  secded_scrubber_if #(.AW(4)) ifs();
  logic       busy_s, done_s, bv_s;
  logic [7:0] corr_s, uncorr_s;
  logic [3:0] fba_s;
  logic [14:0] dr_s;

  secded_scrubber #(.DEPTH(16), .AW(4)) u_dut (
    .clock(clock), .reset(reset), .start(start_s), .abort(abort_s), .bus(ifs),
    .busy(busy_s), .done(done_s), .corr_count(corr_s), .uncorr_count(uncorr_s),
    .bad_valid(bv_s), .first_bad_addr(fba_s)
  );

  assign dr_s              = dec(ifs.dec_inCode);
  assign ifs.dec_outCode   = dr_s[12:0];
  assign ifs.dec_is1BitErr = dr_s[13];
  assign ifs.dec_is2BitErr = dr_s[14];

  logic [12:0] ram_s [16];
  logic [12:0] init_s [16];
  logic [12:0] gold_s [16];
  logic        load_s = 1'b0;

  always @(posedge clock) begin
    if (load_s) begin
      for (int i = 0; i < 16; i++) ram_s[i] <= init_s[i];
    end else if (ifs.mem_we) begin
      ram_s[ifs.mem_addr] <= ifs.mem_wdata;
    end
    if (ifs.mem_re) ifs.mem_rdata <= ram_s[ifs.mem_addr];
  end

  int ndone_s = 0, nwr_s = 0, nboth = 0, done_cyc_s = 0;
  logic [3:0]  wr_addr_s;
  logic [12:0] wr_data_s;
  always @(negedge clock) begin
    if (done_s) begin ndone_s++; done_cyc_s = cyc; end
    if (ifs.mem_we) begin nwr_s++; wr_addr_s = ifs.mem_addr; wr_data_s = ifs.mem_wdata; end
    if (ifs.mem_re && ifs.mem_we) nboth++;
  end

  // ---------------- 300-word instance ----------------
  secded_scrubber_if #(.AW(9)) ifb();
  logic       busy_b, done_b, bv_b;
  logic [7:0] corr_b, uncorr_b;
  logic [8:0] fba_b;
  logic [14:0] dr_b;

  secded_scrubber #(.DEPTH(300), .AW(9)) u_big (
    .clock(clock), .reset(reset), .start(start_b), .abort(1'b0), .bus(ifb),
    .busy(busy_b), .done(done_b), .corr_count(corr_b), .uncorr_count(uncorr_b),
    .bad_valid(bv_b), .first_bad_addr(fba_b)
  );

  assign dr_b              = dec(ifb.dec_inCode);
  assign ifb.dec_outCode   = dr_b[12:0];
  assign ifb.dec_is1BitErr = dr_b[13];
  assign ifb.dec_is2BitErr = dr_b[14];

  logic [12:0] ram_b [300];
  logic [12:0] init_b [300];
  logic        load_b = 1'b0;

  always @(posedge clock) begin
    if (load_b) begin
      for (int i = 0; i < 300; i++) ram_b[i] <= init_b[i];
    end else if (ifb.mem_we) begin
      ram_b[ifb.mem_addr] <= ifb.mem_wdata;
    end
    if (ifb.mem_re) ifb.mem_rdata <= ram_b[ifb.mem_addr];
  end

  int ndone_b = 0, nwr_b = 0, done_cyc_b = 0;
  always @(negedge clock) begin
    if (done_b) begin ndone_b++; done_cyc_b = cyc; end
    if (ifb.mem_we) nwr_b++;
  end

  // ---------------- helpers ----------------
  int s0;
  int base_done, base_wr;

  task automatic prep(input int w1, input logic [12:0] m1, input int w2, input logic [12:0] m2);
    for (int i = 0; i < 16; i++)
      init_s[i] = gold_s[i] ^ ((i == w1) ? m1 : 13'd0) ^ ((i == w2) ? m2 : 13'd0);
    @(negedge clock); load_s = 1'b1;
    @(negedge clock); load_s = 1'b0;
  endtask

  task automatic kick();
    @(negedge clock); start_s = 1'b1;
    @(posedge clock); #1 s0 = cyc; start_s = 1'b0;
    base_done = ndone_s;
    base_wr   = nwr_s;
    @(negedge clock);
    chk("first_read_re", ifs.mem_re, 1);
    chk("first_read_addr", ifs.mem_addr, 0);
  endtask

  task automatic run_scan(input bit pokes);
    int n;
    kick();
    n = 0;
    while (busy_s && n < 200) begin
      start_s = pokes && (n == 4 || n == 9);
      @(negedge clock);
      n++;
    end
    start_s = 1'b0;
    if (busy_s) chk("scan_timeout", busy_s, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; start_s = 1'b0; abort_s = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 16; i++) gold_s[i] = enc(8'(i * 37 + 5));
    repeat (3) @(negedge clock);

    // reset values
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_corr", corr_s, 0);
    chk("rst_uncorr", uncorr_s, 0);
    chk("rst_bad_valid", bv_s, 0);
    chk("rst_first_bad", fba_s, 0);
    chk("rst_re", ifs.mem_re, 0);
    chk("rst_we", ifs.mem_we, 0);
    chk("rst_wdata", ifs.mem_wdata, 0);
    chk("rst_incode", ifs.dec_inCode, 0);
    chk("rst_addr", ifs.mem_addr, 0);
    reset = 1'b0;

    // clean scan with stray start pulses while busy
    prep(-1, 13'd0, -1, 13'd0);
    run_scan(1'b1);
    chk("clean_done_cycle", done_cyc_s - s0 + 1, 33);
    chk("clean_done_pulses", ndone_s - base_done, 1);
    chk("clean_corr", corr_s, 0);
    chk("clean_uncorr", uncorr_s, 0);
    chk("clean_bad_valid", bv_s, 0);
    chk("clean_writes", nwr_s - base_wr, 0);

    // single-bit error: word 5 bit 6
    prep(5, 13'h0040, -1, 13'd0);
    run_scan(1'b0);
    chk("sbe_done_cycle", done_cyc_s - s0 + 1, 34);
    chk("sbe_writes", nwr_s - base_wr, 1);
    chk("sbe_wr_addr", wr_addr_s, 5);
    chk("sbe_wr_data", wr_data_s, gold_s[5]);
    chk("sbe_ram_fixed", ram_s[5], gold_s[5]);
    chk("sbe_corr", corr_s, 1);
    run_scan(1'b0);
    chk("sbe_rescan_corr", corr_s, 0);
    chk("sbe_rescan_writes", nwr_s - base_wr, 0);

    // double-bit errors: word 3 bits 0,4 and word 9 bits 2,7
    prep(3, 13'h0011, 9, 13'h0084);
    run_scan(1'b0);
    chk("dbe_done_cycle", done_cyc_s - s0 + 1, 33);
    chk("dbe_uncorr", uncorr_s, 2);
    chk("dbe_first_bad", fba_s, 3);
    chk("dbe_bad_valid", bv_s, 1);
    chk("dbe_writes", nwr_s - base_wr, 0);
    chk("dbe_corr", corr_s, 0);

    // abort during word 7 CHECK after one correction (word 2)
    prep(2, 13'h0040, -1, 13'd0);
    kick();
    n = 0;
    while (!(ifs.mem_re && ifs.mem_addr == 4'd7) && n < 100) begin
      @(negedge clock); n++;
    end
    chk("abort_reached_w7", ifs.mem_addr, 7);
    @(negedge clock);
    chk("abort_incode", ifs.dec_inCode, gold_s[7]);
    abort_s = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", busy_s, 0);
    @(negedge clock); abort_s = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_no_done", ndone_s - base_done, 0);
    chk("abort_corr_kept", corr_s, 1);
    chk("abort_busy_after", busy_s, 0);

    // reset while a WRITE is presented (word 4)
    prep(4, 13'h0100, -1, 13'd0);
    kick();
    n = 0;
    while (!ifs.mem_we && n < 100) begin
      @(negedge clock); n++;
    end
    chk("rstw_wr_addr", ifs.mem_addr, 4);
    reset = 1'b1;
    #1;
    chk("rstw_busy", busy_s, 0);
    chk("rstw_we", ifs.mem_we, 0);
    chk("rstw_wdata", ifs.mem_wdata, 0);
    chk("rstw_corr", corr_s, 0);
    @(negedge clock); reset = 1'b0;
    chk("rstw_write_dropped", ram_s[4], gold_s[4] ^ 13'h0100);
    run_scan(1'b0);
    chk("rstw_rescan_corr", corr_s, 1);
    chk("rstw_rescan_done_cycle", done_cyc_s - s0 + 1, 34);
    chk("rstw_ram_fixed", ram_s[4], gold_s[4]);

    // 300 words, every one single-bit corrupted: counter saturates
    for (int i = 0; i < 300; i++) init_b[i] = enc(8'(i)) ^ (13'd1 << (i % 13));
    @(negedge clock); load_b = 1'b1;
    @(negedge clock); load_b = 1'b0; start_b = 1'b1;
    @(posedge clock); #1 s0 = cyc; start_b = 1'b0;
    n = 0;
    @(negedge clock);
    while (busy_b && n < 1200) begin
      @(negedge clock); n++;
    end
    if (busy_b) chk("big_timeout", busy_b, 0);
    chk("big_corr_sat", corr_b, 255);
    chk("big_uncorr", uncorr_b, 0);
    chk("big_done_pulses", ndone_b, 1);
    chk("big_done_cycle", done_cyc_b - s0 + 1, 901);
    chk("big_writes", nwr_b, 300);
    chk("big_ram_last", ram_b[299], enc(8'd43));

    chk("re_we_exclusive", nboth, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
